// File: rtl/neuromorphic_x1_wb_bridge.sv
// rtl/neuromorphic_x1_wb_bridge.sv - Wishbone classic slave driving the NEUROMORPHIC_X1 functional port
//
// Purpose: decodes an address window on the SoC Wishbone bus and turns each hit
// into a single macro request (EN held high) that waits for func_ack. Read data or
// write completion is returned as a one-cycle wbs_ack_o. If func_ack does not come
// within TIMEOUT_CYCLES EN-high cycles, a one-cycle wbs_err_o is returned instead,
// with TIMEOUT_DATA on wbs_dat_o.
//
// Ports:
//   CLKin, RSTin            clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i    byte selects, address
//   wbs_dat_i / wbs_dat_o   write data / read data
//   wbs_ack_o, wbs_err_o    transfer acknowledge, timeout error acknowledge
//   EN, R_WB                macro request, 1 = read / 0 = write
//   DI, AD, SEL             macro write data, offset address, byte select
//   DO, func_ack            macro read data, macro acknowledge
//   busy_o                  high while a transfer is in flight (FSM not IDLE)
module neuromorphic_x1_wb_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] DI,
  output logic [31:0] AD,
  output logic [3:0]  SEL,
  input  logic [31:0] DO,
  input  logic        func_ack,
  output logic        busy_o
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          en_q, en_d;
  logic          r_wb_q, r_wb_d;
  logic [31:0]   di_q, di_d;
  logic [31:0]   ad_q, ad_d;
  logic [3:0]    sel_q, sel_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;

  logic hit;
  logic bus_gone;
  logic last_cycle;

  assign hit        = wbs_cyc_i & wbs_stb_i &
                      ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  // Once the master drops cyc during ISSUE the transfer is orphaned for good,
  // even if cyc comes back before the macro answers.
  assign bus_gone   = abort_q | ~wbs_cyc_i;
  assign last_cycle = (cnt_q == CNT_LAST);

  // State register and all registered outputs
  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      r_wb_q  <= 1'b1;
      di_q    <= 32'h0;
      ad_q    <= 32'h0;
      sel_q   <= 4'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'h0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      r_wb_q  <= r_wb_d;
      di_q    <= di_d;
      ad_q    <= ad_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ISSUE;
      ISSUE:   if (func_ack || last_cycle) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    en_d    = en_q;
    r_wb_d  = r_wb_q;
    di_d    = di_q;
    ad_d    = ad_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          en_d    = 1'b1;
          r_wb_d  = ~wbs_we_i;
          di_d    = wbs_dat_i;
          ad_d    = wbs_adr_i & ~ADDR_MASK;
          sel_d   = wbs_sel_i;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      ISSUE: begin
        abort_d = bus_gone;
        if (func_ack) begin
          // An ack on the last allowed cycle still completes normally
          en_d = 1'b0;
          if (!bus_gone) begin
            ack_d = 1'b1;
            dat_d = r_wb_q ? DO : 32'h0;
          end
        end else if (last_cycle) begin
          en_d = 1'b0;
          if (!bus_gone) begin
            err_d = 1'b1;
            dat_d = TIMEOUT_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;
  assign EN        = en_q;
  assign R_WB      = r_wb_q;
  assign DI        = di_q;
  assign AD        = ad_q;
  assign SEL       = sel_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_neuromorphic_x1_wb_bridge.sv
// tb/tb_neuromorphic_x1_wb_bridge.sv - directed self-checking bench for neuromorphic_x1_wb_bridge
module tb_neuromorphic_x1_wb_bridge;

  logic        CLKin;
  logic        RSTin;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbs_dat_o;
  logic        EN, R_WB;
  logic [31:0] DI, AD;
  logic [3:0]  SEL;
  logic [31:0] DO;
  logic        func_ack;
  logic        busy_o;

  int n_checks;
  int n_errors;

  neuromorphic_x1_wb_bridge #(
    .BASE_ADDR     (32'h3000_0000),
    .ADDR_MASK     (32'hFFFF_0000),
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_DATA  (32'hDEAD_BEEF)
  ) dut (
    .CLKin    (CLKin),
    .RSTin    (RSTin),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_err_o(wbs_err_o),
    .wbs_dat_o(wbs_dat_o),
    .EN       (EN),
    .R_WB     (R_WB),
    .DI       (DI),
    .AD       (AD),
    .SEL      (SEL),
    .DO       (DO),
    .func_ack (func_ack),
    .busy_o   (busy_o)
  );

  initial CLKin = 1'b0;
  always #5 CLKin = ~CLKin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKin);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  task automatic idle_bus();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_adr_i = 32'h0;
    wbs_dat_i = 32'h0;
    wbs_sel_i = 4'h0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RSTin    = 1'b1;
    func_ack = 1'b0;
    DO       = 32'h0;
    idle_bus();
    tick();
    tick();

    // Reset values
    check("rst_en",   {31'h0, EN}, 32'h0);
    check("rst_rwb",  {31'h0, R_WB}, 32'h1);
    check("rst_ack",  {31'h0, wbs_ack_o}, 32'h0);
    check("rst_err",  {31'h0, wbs_err_o}, 32'h0);
    check("rst_dat",  wbs_dat_o, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    RSTin = 1'b0;
    tick();

    // Write, macro acks after three EN cycles
    req(1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wr_en",   {31'h0, EN}, 32'h1);
      check("wr_ad",   AD, 32'h0000_0010);
      check("wr_di",   DI, 32'hA5A5_1234);
      check("wr_rwb",  {31'h0, R_WB}, 32'h0);
      check("wr_sel",  {28'h0, SEL}, 32'hF);
      check("wr_noack", {31'h0, wbs_ack_o}, 32'h0);
      if (i == 2) func_ack = 1'b1;
      tick();
    end
    check("wr_en_off", {31'h0, EN}, 32'h0);
    check("wr_ack",    {31'h0, wbs_ack_o}, 32'h1);
    check("wr_err",    {31'h0, wbs_err_o}, 32'h0);
    check("wr_dat",    wbs_dat_o, 32'h0);
    func_ack = 1'b0;
    idle_bus();
    tick();
    check("wr_ack_1cyc", {31'h0, wbs_ack_o}, 32'h0);
    check("wr_idle",     {31'h0, busy_o}, 32'h0);

    // Read, macro acks in the first EN cycle
    req(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    DO = 32'hCAFE_F00D;
    tick();
    check("rd_en",  {31'h0, EN}, 32'h1);
    check("rd_rwb", {31'h0, R_WB}, 32'h1);
    check("rd_ad",  AD, 32'h0000_0004);
    func_ack = 1'b1;
    tick();
    check("rd_ack", {31'h0, wbs_ack_o}, 32'h1);
    check("rd_dat", wbs_dat_o, 32'hCAFE_F00D);
    check("rd_en_off", {31'h0, EN}, 32'h0);
    func_ack = 1'b0;
    idle_bus();
    tick();
    check("rd_dat_hold", wbs_dat_o, 32'hCAFE_F00D);

    // Miss for 10 cycles, with a stray func_ack while EN is low
    req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
    func_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("miss_en",   {31'h0, EN}, 32'h0);
      check("miss_ack",  {31'h0, wbs_ack_o}, 32'h0);
      check("miss_err",  {31'h0, wbs_err_o}, 32'h0);
      check("miss_busy", {31'h0, busy_o}, 32'h0);
    end
    check("miss_dat", wbs_dat_o, 32'hCAFE_F00D);
    func_ack = 1'b0;
    idle_bus();
    tick();

    // Timeout: no func_ack, EN high for 4 cycles then err
    req(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    tick();
    check("to_en0", {31'h0, EN}, 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("to_en",  {31'h0, EN}, 32'h1);
      check("to_err_early", {31'h0, wbs_err_o}, 32'h0);
    end
    tick();
    check("to_en_off", {31'h0, EN}, 32'h0);
    check("to_err",    {31'h0, wbs_err_o}, 32'h1);
    check("to_noack",  {31'h0, wbs_ack_o}, 32'h0);
    check("to_dat",    wbs_dat_o, 32'hDEAD_BEEF);
    idle_bus();
    tick();
    check("to_err_1cyc", {31'h0, wbs_err_o}, 32'h0);
    check("to_idle",     {31'h0, busy_o}, 32'h0);

    // func_ack on the 4th (last allowed) cycle wins over the timeout
    req(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    DO = 32'h1234_5678;
    tick();
    tick();
    tick();
    tick();
    check("edge_en", {31'h0, EN}, 32'h1);
    func_ack = 1'b1;
    tick();
    check("edge_ack", {31'h0, wbs_ack_o}, 32'h1);
    check("edge_err", {31'h0, wbs_err_o}, 32'h0);
    check("edge_dat", wbs_dat_o, 32'h1234_5678);
    func_ack = 1'b0;
    idle_bus();
    tick();

    // Bus abort: cyc drops during ISSUE, macro acks later
    req(1'b1, 32'h3000_0020, 32'h1111_2222, 4'h3);
    tick();
    check("ab_en", {31'h0, EN}, 32'h1);
    idle_bus();
    tick();
    check("ab_en_hold", {31'h0, EN}, 32'h1);
    check("ab_di_hold", DI, 32'h1111_2222);
    func_ack = 1'b1;
    tick();
    check("ab_en_off", {31'h0, EN}, 32'h0);
    check("ab_noack",  {31'h0, wbs_ack_o}, 32'h0);
    check("ab_noerr",  {31'h0, wbs_err_o}, 32'h0);
    func_ack = 1'b0;
    tick();
    check("ab_idle", {31'h0, busy_o}, 32'h0);

    // Asynchronous reset mid-ISSUE
    req(1'b1, 32'h3000_0030, 32'h7777_8888, 4'hC);
    tick();
    check("rs_en_before", {31'h0, EN}, 32'h1);
    #2;
    RSTin = 1'b1;
    #1;
    check("rs_en",   {31'h0, EN}, 32'h0);
    check("rs_rwb",  {31'h0, R_WB}, 32'h1);
    check("rs_di",   DI, 32'h0);
    check("rs_ad",   AD, 32'h0);
    check("rs_sel",  {28'h0, SEL}, 32'h0);
    check("rs_dat",  wbs_dat_o, 32'h0);
    check("rs_busy", {31'h0, busy_o}, 32'h0);
    idle_bus();
    tick();
    RSTin = 1'b0;
    tick();

    // Back-to-back: read then write with stb held
    req(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    DO = 32'hCAFE_F00D;
    tick();
    check("bb_rd_en", {31'h0, EN}, 32'h1);
    func_ack = 1'b1;
    tick();
    check("bb_rd_ack", {31'h0, wbs_ack_o}, 32'h1);
    check("bb_rd_dat", wbs_dat_o, 32'hCAFE_F00D);
    check("bb_gap1",   {31'h0, EN}, 32'h0);
    func_ack = 1'b0;
    req(1'b1, 32'h3000_0010, 32'h5555_AAAA, 4'hF);
    tick();
    check("bb_gap2",   {31'h0, EN}, 32'h0);
    check("bb_ack_lo", {31'h0, wbs_ack_o}, 32'h0);
    tick();
    check("bb_wr_en",  {31'h0, EN}, 32'h1);
    check("bb_wr_rwb", {31'h0, R_WB}, 32'h0);
    check("bb_wr_di",  DI, 32'h5555_AAAA);
    func_ack = 1'b1;
    tick();
    check("bb_wr_ack", {31'h0, wbs_ack_o}, 32'h1);
    check("bb_wr_dat", wbs_dat_o, 32'h0);
    func_ack = 1'b0;
    idle_bus();
    tick();
    check("bb_idle", {31'h0, busy_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/neuromorphic_x1_wb_bridge.md
Name: neuromorphic_x1_wb_bridge

Overview:
- Wishbone classic slave that acts as the initiator on the NEUROMORPHIC_X1 functional port (EN, R_WB, DI, AD, SEL, DO, func_ack).
- Decodes a bus address window and holds a single macro request until func_ack arrives.
- Returns read data or write completion to the bus, with a bounded timeout.
- Sits between the SoC Wishbone interconnect and the X1 macro.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the decoded window.
- ADDR_MASK, 32'hFFFF_0000, mask bits compared against BASE_ADDR; the unmasked bits form the macro offset.
- TIMEOUT_CYCLES, 255, maximum EN-high cycles without func_ack before aborting; must be ≥ 1.
- TIMEOUT_DATA, 32'hDEAD_BEEF, value driven on wbs_dat_o during an error response.

Ports:
- CLKin in 1: clock.
- RSTin in 1: asynchronous reset, active-high.
- wbs_cyc_i in 1: Wishbone cycle.
- wbs_stb_i in 1: Wishbone strobe.
- wbs_we_i in 1: 1 = write.
- wbs_sel_i in 4: byte selects.
- wbs_adr_i in 32: address.
- wbs_dat_i in 32: write data.
- wbs_ack_o out 1: transfer acknowledge.
- wbs_err_o out 1: timeout error acknowledge.
- wbs_dat_o out 32: read data.
- EN out 1: macro request.
- R_WB out 1: 1 = read, 0 = write.
- DI out 32: macro write data.
- AD out 32: macro address (offset = wbs_adr_i & ~ADDR_MASK).
- SEL out 4: macro byte select.
- DO in 32: macro read data.
- func_ack in 1: macro acknowledge.
- busy_o out 1: high whenever the FSM is not IDLE.

Behaviour:
- Reset values (asynchronous, immediate, also mid-transaction): EN=0, R_WB=1, DI=0, AD=0, SEL=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, busy_o=0, timeout counter=0, FSM=IDLE.
- FSM states: IDLE, ISSUE, RESP.
- Hit condition: wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)).
- IDLE:
  - On a hit at edge t0: register AD, DI=wbs_dat_i, SEL=wbs_sel_i, R_WB=~wbs_we_i; set EN=1; clear the counter; go to ISSUE.
  - On a miss: no response; all outputs hold.
- ISSUE:
  - EN=1; AD, DI, SEL and R_WB are stable for the whole time EN is high.
  - func_ack=1 sampled at edge t1:
    - EN=0 and go to RESP.
    - If the request was a read, wbs_dat_o=DO captured at t1; if a write, wbs_dat_o=0.
    - wbs_ack_o=1 for the single cycle t1..t1+1.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with func_ack=0:
    - EN=0, wbs_dat_o=TIMEOUT_DATA, wbs_err_o=1 for one cycle; go to RESP.
  - func_ack on the final allowed cycle wins over the timeout.
- Bus abort: if wbs_cyc_i drops during ISSUE, the macro request still runs to func_ack or timeout, but wbs_ack_o and wbs_err_o stay 0 for that transfer.
- RESP: one cycle (ack or err visible), then IDLE. wbs_ack_o and wbs_err_o are never both 1.
- Back-to-back: a request held or presented in the cycle after RESP is accepted as a new transfer from IDLE.
- Latency: minimum 2 cycles from request sample to ack (func_ack in the first EN cycle), plus macro latency.
- func_ack while EN=0 is ignored.
- Requests arriving while not in IDLE are not sampled.
- wbs_dat_o holds its last value between transfers.
- Counter width is clog2(TIMEOUT_CYCLES+1); it never wraps.

Test Plan:
- Write: adr=3000_0010, dat=A5A5_1234, sel=F; macro acks after 3 EN cycles -> EN high exactly 3 cycles; AD=0000_0010, DI=A5A5_1234, R_WB=0, SEL=F stable throughout; one-cycle wbs_ack_o; wbs_dat_o=0.
- Read: adr=3000_0004; macro DO=CAFE_F00D, acks in the first EN cycle -> wbs_ack_o 2 cycles after request, wbs_dat_o=CAFE_F00D, R_WB=1.
- Miss: adr=4000_0000 with cyc/stb held 10 cycles -> EN stays 0, no ack or err, busy_o=0.
- Timeout: TIMEOUT_CYCLES=4, func_ack held 0 -> EN drops after 4 cycles; wbs_err_o pulses once with wbs_dat_o=DEAD_BEEF; ack never asserted. Separately, func_ack on the 4th cycle -> ack, not err.
- Abort and reset:
  - Drop wbs_cyc_i during ISSUE; macro acks later -> EN drops, no bus ack, returns to IDLE.
  - Assert RSTin mid-ISSUE -> EN=0 immediately without waiting for a clock, all outputs at reset values.
- Back-to-back: read immediately followed by a write with stb held high -> two separate EN episodes, two acks, with at least one EN-low cycle between them.
